alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 190 +++++++++++++++++++
 tb/tb_alu_seq.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: request/response ALU engine with a bit-serial adder path.
// Add, sub and signed-less are computed LSB first, one bit per clock.
// The logic ops and equality finish in a single EXEC cycle.
// Optional macro ALU_SEQ_FAST_ADD_EN: add/sub/less use a combinational adder
// instead, so every op takes one EXEC cycle and no bit counter exists.
//
// state | meaning
// IDLE  | waiting for a request, req_ready=1
// EXEC  | operation in progress (WIDTH cycles serial, 1 cycle otherwise)
// DONE  | result held on outputs, resp_valid=1 until resp_ready

module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       op,
  input  logic             in_c,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_c,
  output logic             zero,
  output logic             overflow
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_LT  = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, next_state;
  logic             accept, load_res, exec_last;

  logic [2:0]       op_q;
  logic [WIDTH-1:0] x_q, y_q;
  logic             carry_q;

  logic [WIDTH-1:0] a_sum;
  logic             a_cout, a_ovf;

  logic [WIDTH-1:0] res_s;
  logic             res_c, res_of;

`ifdef ALU_SEQ_FAST_ADD_EN
  logic [WIDTH-1:0] y_eff;

  // Whole-word adder: y inverted for sub/less, carry_q holds the carry-in.
  always_comb begin
    y_eff             = (op_q == OP_ADD) ? y_q : ~y_q;
    {a_cout, a_sum}   = {1'b0, x_q} + {1'b0, y_eff} + {{WIDTH{1'b0}}, carry_q};
    a_ovf             = (x_q[WIDTH-1] == y_eff[WIDTH-1]) && (a_sum[WIDTH-1] != x_q[WIDTH-1]);
    exec_last         = 1'b1;
  end
`else
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-2:0] acc_q;
  logic             is_arith, y_bit, s_bit;

  // One full-adder slice per cycle; x_q/y_q shift right so bit 0 is current.
  // a_sum is the partial sum with the new bit inserted at the MSB end, which
  // after WIDTH shifts is the complete result.
  always_comb begin
    is_arith  = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_LT);
    y_bit     = y_q[0] ^ (op_q != OP_ADD);
    s_bit     = x_q[0] ^ y_bit ^ carry_q;
    a_cout    = (x_q[0] & y_bit) | (x_q[0] & carry_q) | (y_bit & carry_q);
    a_sum     = {s_bit, acc_q};
    a_ovf     = (x_q[0] == y_bit) && (s_bit != x_q[0]);
    exec_last = !is_arith || (cnt_q == '0);
  end
`endif

  // Final result and flags for the captured op.
  always_comb begin
    res_s  = '0;
    res_c  = 1'b0;
    res_of = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        res_s  = a_sum;
        res_c  = a_cout;
        res_of = a_ovf;
      end
      OP_NOT: res_s = ~x_q;
      OP_AND: res_s = x_q & y_q;
      OP_OR:  res_s = x_q | y_q;
      OP_XOR: res_s = x_q ^ y_q;
      OP_LT:  res_s = {{(WIDTH-1){1'b0}}, a_sum[WIDTH-1] ^ a_ovf};
      OP_EQ:  res_s = {{(WIDTH-1){1'b0}}, x_q == y_q};
      default: res_s = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= next_state;
  end

  // Next-state and handshake decode.
  always_comb begin
    next_state = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    load_res   = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept     = 1'b1;
          next_state = EXEC;
        end
      end
      EXEC: begin
        if (exec_last) begin
          load_res   = 1'b1;
          next_state = DONE;
        end
      end
      DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Operand capture, serial stepping and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      carry_q  <= 1'b0;
      out_s    <= '0;
      out_c    <= 1'b0;
      zero     <= 1'b0;
      overflow <= 1'b0;
`ifndef ALU_SEQ_FAST_ADD_EN
      cnt_q    <= '0;
      acc_q    <= '0;
`endif
    end else begin
      if (accept) begin
        op_q    <= op;
        x_q     <= in_x;
        y_q     <= in_y;
        // sub and less need the +1 of the two's complement; in_c only for add
        carry_q <= (op == OP_ADD) ? in_c : 1'b1;
`ifndef ALU_SEQ_FAST_ADD_EN
        cnt_q   <= CW'(WIDTH-1);
`endif
      end
`ifndef ALU_SEQ_FAST_ADD_EN
      if (state_q == EXEC && is_arith) begin
        x_q     <= x_q >> 1;
        y_q     <= y_q >> 1;
        acc_q   <= a_sum[WIDTH-1:1];
        carry_q <= a_cout;
        if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
      end
`endif
      if (load_res) begin
        out_s    <= res_s;
        out_c    <= res_c;
        zero     <= (res_s == '0);
        overflow <= res_of;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=4). Expected results come from an
// integer reference model, queued when a request is driven and popped when
// resp_valid appears.
module tb_alu_seq;
  localparam int WIDTH = 4;
`ifdef ALU_SEQ_FAST_ADD_EN
  localparam int ARITH_LAT = 1;
`else
  localparam int ARITH_LAT = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid, req_ready;
  logic [2:0]       op;
  logic             in_c;
  logic [WIDTH-1:0] in_x, in_y;
  logic             resp_valid, resp_ready;
  logic [WIDTH-1:0] out_s;
  logic             out_c, zero, overflow;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             z;
    logic             of;
    int               lat;
  } exp_t;

  typedef struct {
    logic [2:0]       o;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             c;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .op(op), .in_c(in_c), .in_x(in_x), .in_y(in_y),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .out_s(out_s), .out_c(out_c), .zero(zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [2:0] o, input logic [WIDTH-1:0] x,
                                 input logic [WIDTH-1:0] y, input logic c);
    exp_t e;
    int ux, uy, sx, sy, r, sr;
    int smax, smin;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    smax = (1 << (WIDTH-1)) - 1;
    smin = -(1 << (WIDTH-1));
    e.s = '0; e.c = 1'b0; e.of = 1'b0; e.lat = 1;
    case (o)
      3'd0: begin
        r = ux + uy + int'(c); sr = sx + sy + int'(c);
        e.s = r[WIDTH-1:0]; e.c = (r >= (1 << WIDTH));
        e.of = (sr > smax) || (sr < smin); e.lat = ARITH_LAT;
      end
      3'd1: begin
        r = ux - uy + (1 << WIDTH); sr = sx - sy;
        e.s = r[WIDTH-1:0]; e.c = (r >= (1 << WIDTH));
        e.of = (sr > smax) || (sr < smin); e.lat = ARITH_LAT;
      end
      3'd2: e.s = ~x;
      3'd3: e.s = x & y;
      3'd4: e.s = x | y;
      3'd5: e.s = x ^ y;
      3'd6: begin e.s = (sx < sy) ? 1 : 0; e.lat = ARITH_LAT; end
      default: e.s = (x == y) ? 1 : 0;
    endcase
    e.z = (e.s == '0);
    return e;
  endfunction

  // Drive one request, scramble inputs after accept, wait (bounded) for resp_valid.
  task automatic run_txn(input logic [2:0] o, input logic [WIDTH-1:0] x,
                         input logic [WIDTH-1:0] y, input logic c, output int lat);
    sb.push_back(model(o, x, y, c));
    req_valid = 1'b1; op = o; in_x = x; in_y = y; in_c = c;
    @(posedge clk); #1;
    req_valid = 1'b0;
    op = 3'($urandom); in_x = WIDTH'($urandom); in_y = WIDTH'($urandom); in_c = 1'($urandom);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!resp_valid && lat < 64);
  endtask

  task automatic take_resp();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    op = '0; in_c = 1'b0; in_x = '0; in_y = '0;
    #3;
    n_checks++;
    if ({out_s, out_c, zero, overflow, req_ready, resp_valid} !== {{WIDTH{1'b0}}, 3'b000, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got s=%h c=%b z=%b of=%b rdy=%b vld=%b, want all 0, rdy=1",
               out_s, out_c, zero, overflow, req_ready, resp_valid);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_arith();
    vec_t v[6];
    exp_t e;
    int lat;
    v[0] = '{3'd0, 4'h7, 4'h1, 1'b0};
    v[1] = '{3'd1, 4'h8, 4'h1, 1'b0};
    v[2] = '{3'd1, 4'h3, 4'h3, 1'b0};
    v[3] = '{3'd0, 4'hF, 4'h1, 1'b1};
    v[4] = '{3'd1, 4'h3, 4'h3, 1'b1};
    v[5] = '{3'd0, 4'h8, 4'h8, 1'b0};
    for (int i = 0; i < 6; i++) begin
      run_txn(v[i].o, v[i].x, v[i].y, v[i].c, lat);
      e = sb.pop_front();
      n_checks++;
      if ({out_s, out_c, zero, overflow} !== {e.s, e.c, e.z, e.of} || lat != e.lat) begin
        n_fail++;
        $display("FAIL arith[%0d] op=%0d x=%h y=%h c=%b: got s=%h c=%b z=%b of=%b lat=%0d, want s=%h c=%b z=%b of=%b lat=%0d",
                 i, v[i].o, v[i].x, v[i].y, v[i].c, out_s, out_c, zero, overflow, lat, e.s, e.c, e.z, e.of, e.lat);
      end
      take_resp();
    end
  endtask

  task automatic test_less_logic();
    vec_t v[9];
    exp_t e;
    int lat;
    v[0] = '{3'd6, 4'hF, 4'h1, 1'b0};
    v[1] = '{3'd6, 4'h1, 4'hF, 1'b0};
    v[2] = '{3'd5, 4'hA, 4'hA, 1'b0};
    v[3] = '{3'd2, 4'h5, 4'h0, 1'b1};
    v[4] = '{3'd3, 4'hC, 4'hA, 1'b0};
    v[5] = '{3'd4, 4'hC, 4'h3, 1'b0};
    v[6] = '{3'd7, 4'h6, 4'h6, 1'b0};
    v[7] = '{3'd7, 4'h6, 4'h7, 1'b0};
    v[8] = '{3'd6, 4'h7, 4'h8, 1'b0};
    for (int i = 0; i < 9; i++) begin
      run_txn(v[i].o, v[i].x, v[i].y, v[i].c, lat);
      e = sb.pop_front();
      n_checks++;
      if ({out_s, out_c, zero, overflow} !== {e.s, e.c, e.z, e.of} || lat != e.lat) begin
        n_fail++;
        $display("FAIL less_logic[%0d] op=%0d x=%h y=%h: got s=%h c=%b z=%b of=%b lat=%0d, want s=%h c=%b z=%b of=%b lat=%0d",
                 i, v[i].o, v[i].x, v[i].y, out_s, out_c, zero, overflow, lat, e.s, e.c, e.z, e.of, e.lat);
      end
      take_resp();
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int lat;
    run_txn(3'd0, 4'h3, 4'h2, 1'b1, lat);
    e = sb.pop_front();
    n_checks++;
    if ({out_s, out_c, zero, overflow} !== {e.s, e.c, e.z, e.of} || lat != e.lat) begin
      n_fail++;
      $display("FAIL bp_result: got s=%h c=%b z=%b of=%b lat=%0d, want s=%h c=%b z=%b of=%b lat=%0d",
               out_s, out_c, zero, overflow, lat, e.s, e.c, e.z, e.of, e.lat);
    end
    for (int k = 0; k < 5; k++) begin
      req_valid = (k % 2 == 0);
      op = 3'($urandom); in_x = WIDTH'($urandom); in_y = WIDTH'($urandom); in_c = 1'($urandom);
      @(posedge clk); #1;
      n_checks++;
      if ({out_s, out_c, zero, overflow} !== {e.s, e.c, e.z, e.of} || req_ready !== 1'b0 || resp_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got s=%h c=%b z=%b of=%b rdy=%b vld=%b, want s=%h c=%b z=%b of=%b rdy=0 vld=1",
                 k, out_s, out_c, zero, overflow, req_ready, resp_valid, e.s, e.c, e.z, e.of);
      end
    end
    // req_valid high on the DONE->IDLE edge must not be taken as an accept
    req_valid = 1'b1; resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; resp_ready = 1'b0;
    n_checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: got rdy=%b vld=%b, want rdy=1 vld=0", req_ready, resp_valid);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int lat;
    int seen;
    run_txn(3'd0, 4'h7, 4'h1, 1'b0, lat);
    e = sb.pop_front();
    n_checks++;
    if ({out_s, out_c, zero, overflow} !== {e.s, e.c, e.z, e.of} || lat != e.lat) begin
      n_fail++;
      $display("FAIL rst_pre: got s=%h c=%b z=%b of=%b lat=%0d, want s=%h c=%b z=%b of=%b lat=%0d",
               out_s, out_c, zero, overflow, lat, e.s, e.c, e.z, e.of, e.lat);
    end
    take_resp();
    req_valid = 1'b1; op = 3'd0; in_x = 4'h5; in_y = 4'h6; in_c = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_s, out_c, zero, overflow, req_ready, resp_valid} !== {{WIDTH{1'b0}}, 3'b000, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_async: got s=%h c=%b z=%b of=%b rdy=%b vld=%b, want all 0, rdy=1",
               out_s, out_c, zero, overflow, req_ready, resp_valid);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (resp_valid) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL rst_discard: got %0d resp_valid cycles, want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int lat;
    logic [2:0] o;
    logic [WIDTH-1:0] x, y;
    logic c;
    for (int i = 0; i < 12; i++) begin
      o = 3'($urandom); x = WIDTH'($urandom); y = WIDTH'($urandom); c = 1'($urandom);
      run_txn(o, x, y, c, lat);
      e = sb.pop_front();
      n_checks++;
      if ({out_s, out_c, zero, overflow} !== {e.s, e.c, e.z, e.of} || lat != e.lat) begin
        n_fail++;
        $display("FAIL b2b[%0d] op=%0d x=%h y=%h c=%b: got s=%h c=%b z=%b of=%b lat=%0d, want s=%h c=%b z=%b of=%b lat=%0d",
                 i, o, x, y, c, out_s, out_c, zero, overflow, lat, e.s, e.c, e.z, e.of, e.lat);
      end
      take_resp();
    end
  endtask

  task automatic test_sweep();
    exp_t e;
    int lat;
    for (int o = 0; o < 8; o++)
      for (int i = 0; i < (1 << WIDTH); i++)
        for (int j = 0; j < (1 << WIDTH); j++)
          for (int c = 0; c < 2; c++) begin
            run_txn(3'(o), WIDTH'(i), WIDTH'(j), 1'(c), lat);
            e = sb.pop_front();
            n_checks++;
            if ({out_s, out_c, zero, overflow} !== {e.s, e.c, e.z, e.of} || lat != e.lat) begin
              n_fail++;
              $display("FAIL sweep op=%0d x=%h y=%h c=%0d: got s=%h c=%b z=%b of=%b lat=%0d, want s=%h c=%b z=%b of=%b lat=%0d",
                       o, i, j, c, out_s, out_c, zero, overflow, lat, e.s, e.c, e.z, e.of, e.lat);
            end
            take_resp();
          end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_less_logic();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
